lsu_mem_stage: RTL

//  Memory-access stage directly downstream of the ALU: takes ALUOut as effective address or result.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/lsu_mem_stage_if.sv | 14 +
 rtl/lsu_mem_stage_align.sv | 30 +++
 rtl/lsu_mem_stage.sv | 111 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: access-size encodings and LSU state type shared by the memory stage.
package riscv_pkg;
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_e;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction
endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: req/gnt/rvalid data-memory port between the LSU (master) and memory (slave).
interface lsu_mem_stage_if #(parameter int WORDS = 32);
    logic             req;
    logic             we;
    logic [WORDS-1:0] addr;
    logic [WORDS-1:0] wdata;
    logic [3:0]       be;
    logic             gnt;
    logic             rvalid;
    logic [WORDS-1:0] rdata;

    modport master(output req, we, addr, wdata, be, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: byte-enable / lane-replicated store data generation and load extraction with extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        be = st_f3[1:0] == 2'b00 ? 4'b0001 << st_off
           : st_f3[1:0] == 2'b01 ? 4'b0011 << {st_off[1], 1'b0} : 4'b1111;
        wdata = st_f3[1:0] == 2'b00 ? {4{st_data[7:0]}}
              : st_f3[1:0] == 2'b01 ? {2{st_data[15:0]}} : st_data;
        b = rdata[{ld_off, 3'b000} +: 8];
        h = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = ld_f3 == F3_B  ? {{24{b[7]}}, b}
                : ld_f3 == F3_BU ? {24'b0, b}
                : ld_f3 == F3_H  ? {{16{h[15]}}, h}
                : ld_f3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage driving a req/gnt/rvalid data port and a one-beat writeback.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of truncating the offset.
module lsu_mem_stage
    import riscv_pkg::*;
#(
    parameter int WORDS   = 32,
    parameter int REGBITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          funct3,
    input  logic [WORDS-1:0]    ALUOut,
    input  logic [WORDS-1:0]    StoreData,
    input  logic [REGBITS-1:0]  rd_in,
    lsu_mem_stage_if.master     dmem,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [REGBITS-1:0]  wb_rd,
    output logic [WORDS-1:0]    wb_data,
    output logic                wb_err
);
    lsu_state_e         state, nxt;
    logic [2:0]         ld_f3;
    logic [1:0]         ld_off, off_eff;
    logic [REGBITS-1:0] rd_q;
    logic [3:0]         st_be;
    logic [WORDS-1:0]   st_wdata, ld_data;
    logic               mem_op, illegal, misal, err, go_mem;

    assign ex_ready = state == IDLE;
    assign mem_op   = MemRead | MemWrite;
    assign illegal  = mem_op & (!f3_legal(funct3) | (MemWrite & funct3[2]) | (MemRead & MemWrite));
    // Dropping the offending low bits is harmless for aligned accesses, so it applies in both builds.
    assign off_eff  = funct3[1] ? 2'b00 : funct3[0] ? {ALUOut[1], 1'b0} : ALUOut[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    assign misal    = mem_op & ((funct3[1:0] == 2'b01 & ALUOut[0]) | (funct3 == F3_W & |ALUOut[1:0]));
`else
    assign misal    = 1'b0;
`endif
    assign err      = illegal | misal;
    assign go_mem   = ex_valid & ex_ready & mem_op & !err;

    lsu_align u_align (
        .st_f3(funct3), .st_off(off_eff), .st_data(StoreData),
        .ld_f3(ld_f3), .ld_off(ld_off), .rdata(dmem.rdata),
        .be(st_be), .wdata(st_wdata), .ld_data(ld_data)
    );

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : nxt;

    always_comb begin
        nxt = state;
        if (state == IDLE && go_mem) nxt = REQ;
        else if (state == REQ && dmem.gnt) nxt = dmem.we ? IDLE : WAIT;
        else if (state == WAIT && dmem.rvalid) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem.req <= 1'b0;
            dmem.we <= 1'b0;
            dmem.addr <= '0;
            dmem.wdata <= '0;
            dmem.be <= 4'b0;
            wb_valid <= 1'b0;
            wb_we <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
            wb_err <= 1'b0;
            ld_f3 <= 3'b0;
            ld_off <= 2'b0;
            rd_q <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we <= 1'b0;
            wb_err <= 1'b0;
            if (go_mem) begin
                dmem.req <= 1'b1;
                dmem.we <= MemWrite;
                dmem.addr <= {ALUOut[WORDS-1:2], 2'b00};
                dmem.wdata <= st_wdata;
                dmem.be <= st_be;
                ld_f3 <= funct3;
                ld_off <= off_eff;
                rd_q <= rd_in;
            end else if (ex_valid && ex_ready) begin
                wb_valid <= 1'b1;
                wb_we <= !err & |rd_in;
                wb_err <= err;
                wb_rd <= rd_in;
                wb_data <= ALUOut;
            end
            if (state == REQ && dmem.gnt) begin
                dmem.req <= 1'b0;
                wb_valid <= dmem.we;
                wb_rd <= rd_q;
            end
            if (state == WAIT && dmem.rvalid) begin
                wb_valid <= 1'b1;
                wb_we <= |rd_q;
                wb_rd <= rd_q;
                wb_data <= ld_data;
            end
        end
    end
endmodule
